// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the multi-channel debounce block.
//   MODE_FAST : fast-attack / delayed-release channel mode
//   MODE_SYM  : symmetric channel mode (both edges need a full hold run)
//   cnt_width : width of the per-channel hold counter for a given hold count
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam logic MODE_FAST = 1'b0;
    localparam logic MODE_SYM  = 1'b1;

    // The counter only ever reaches hold-1, but it is sized for hold so that
    // a hold count of 1 still gets a legal one-bit counter.
    function automatic int cnt_width(input int hold);
        if (hold < 1) begin
            return 1;
        end
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// -----------------------------------------------------------------------------
// debounce_multi_if
// Bundles the per-channel debounce signals.
//   tick  : sample enable shared by every channel
//   mode  : per-channel mode select (see debounce_pkg)
//   din   : raw asynchronous inputs
//   dout  : debounced levels
//   rise  : one-cycle pulse when dout goes 0->1
//   fall  : one-cycle pulse when dout goes 1->0
// The master modport belongs to whoever drives the raw pins and consumes the
// debounced result; the slave modport belongs to the debouncer.
// -----------------------------------------------------------------------------
interface debounce_multi_if #(
    parameter int N_CH = 4
);
    import debounce_pkg::*;

    logic            tick;
    logic [N_CH-1:0] mode;
    logic [N_CH-1:0] din;
    logic [N_CH-1:0] dout;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    modport master (
        output tick,
        output mode,
        output din,
        input  dout,
        input  rise,
        input  fall
    );

    modport slave (
        input  tick,
        input  mode,
        input  din,
        output dout,
        output rise,
        output fall
    );

endinterface

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// One debounce channel: input synchroniser, hold counter, debounced level and
// registered edge pulses.
//   clk     : clock
//   rst_p   : asynchronous active-high reset
//   tick_i  : sample enable; the hold counter only advances when high
//   mode_i  : MODE_FAST or MODE_SYM
//   din_i   : raw asynchronous input
//   dout_o  : debounced level (0 = idle/released)
//   rise_o  : pulse in the cycle dout_o goes 0->1
//   fall_o  : pulse in the cycle dout_o goes 1->0
// -----------------------------------------------------------------------------
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int HOLD_CYCLES = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_p,
    input  logic tick_i,
    input  logic mode_i,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CW      = cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   din_s;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   dout_q;
    logic                   dout_d;
    logic                   rise_q;
    logic                   fall_q;
    logic                   rise_d;
    logic                   fall_d;

    // Metastability guard: the raw pin walks through SYNC_STAGES flops and
    // only the last stage is ever looked at by the counter logic.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    assign din_s = sync_q[SYNC_STAGES-1];

    // Hold-off decision. Any sample that agrees with the current level
    // clears the counter even on a non-tick cycle, so a glitch between ticks
    // still restarts the hold run. In fast mode a high sample is taken
    // immediately; only the release waits out the hold run.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (mode_i == MODE_FAST) begin
            if (din_s) begin
                dout_d = 1'b1;
                cnt_d  = '0;
            end else if (!dout_q) begin
                cnt_d = '0;
            end else if (tick_i) begin
                if (cnt_q == CNT_MAX) begin
                    dout_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else begin
            if (din_s == dout_q) begin
                cnt_d = '0;
            end else if (tick_i) begin
                if (cnt_q == CNT_MAX) begin
                    dout_d = din_s;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Edge pulses are derived from the next level so they land in the same
    // cycle the registered level changes.
    assign rise_d = dout_d & ~dout_q;
    assign fall_d = ~dout_d & dout_q;

    // Channel state registers.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout_o = dout_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
// N-channel debounce / hold-off block. Each channel is fully independent; the
// only shared input is the sample tick carried on the bus.
//   clk    : clock
//   rst_p  : asynchronous active-high reset
//   bus    : debounce_multi_if slave (tick, mode, din in; dout, rise, fall out)
// -----------------------------------------------------------------------------
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_p,
    debounce_multi_if.slave    bus
);

    logic [N_CH-1:0] dout_w;
    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] fall_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_chan #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk    (clk),
            .rst_p  (rst_p),
            .tick_i (bus.tick),
            .mode_i (bus.mode[i]),
            .din_i  (bus.din[i]),
            .dout_o (dout_w[i]),
            .rise_o (rise_w[i]),
            .fall_o (fall_w[i])
        );
    end

    assign bus.dout = dout_w;
    assign bus.rise = rise_w;
    assign bus.fall = fall_w;

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
// Drives two debounce_multi instances (hold 5 and hold 1) from the same
// stimulus and compares both against a behavioural model every cycle, with
// directed scenarios pinned by hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

    localparam int NCH  = 4;
    localparam int SYNC = 2;

    logic            clk   = 1'b0;
    logic            rst_p = 1'b0;
    logic            tick  = 1'b1;
    logic [NCH-1:0]  mode  = '0;
    logic [NCH-1:0]  din   = '0;

    int  checks   = 0;
    int  passes   = 0;
    bit  checkEn  = 1'b0;

    always #5 clk = ~clk;

    debounce_multi_if #(.N_CH(NCH)) busA ();
    debounce_multi_if #(.N_CH(NCH)) busB ();

    assign busA.tick = tick;
    assign busA.mode = mode;
    assign busA.din  = din;
    assign busB.tick = tick;
    assign busB.mode = mode;
    assign busB.din  = din;

    debounce_multi #(.N_CH(NCH), .HOLD_CYCLES(5), .SYNC_STAGES(SYNC)) dutA (
        .clk   (clk),
        .rst_p (rst_p),
        .bus   (busA)
    );

    debounce_multi #(.N_CH(NCH), .HOLD_CYCLES(1), .SYNC_STAGES(SYNC)) dutB (
        .clk   (clk),
        .rst_p (rst_p),
        .bus   (busB)
    );

    // Reference model: din_s is din delayed by SYNC clock edges; each channel
    // tracks how many consecutive qualifying tick-samples it has seen.
    logic [NCH-1:0] hist  [SYNC];
    logic [NCH-1:0] mDout [2];
    logic [NCH-1:0] mRise [2];
    logic [NCH-1:0] mFall [2];
    int             mRun  [2][NCH];

    function automatic int holdOf(input int k);
        return (k == 0) ? 5 : 1;
    endfunction

    always @(posedge clk or posedge rst_p) begin : model
        logic [NCH-1:0] s;
        logic [NCH-1:0] nd;
        if (rst_p) begin
            for (int i = 0; i < SYNC; i++) hist[i] = '0;
            for (int k = 0; k < 2; k++) begin
                mDout[k] = '0;
                mRise[k] = '0;
                mFall[k] = '0;
                for (int c = 0; c < NCH; c++) mRun[k][c] = 0;
            end
        end else begin
            s = hist[SYNC-1];
            for (int k = 0; k < 2; k++) begin
                nd = mDout[k];
                for (int c = 0; c < NCH; c++) begin
                    if (mode[c] == 1'b0 && s[c]) begin
                        nd[c] = 1'b1;
                        mRun[k][c] = 0;
                    end else if (s[c] == mDout[k][c]) begin
                        mRun[k][c] = 0;
                    end else if (tick) begin
                        mRun[k][c] = mRun[k][c] + 1;
                        if (mRun[k][c] >= holdOf(k)) begin
                            nd[c] = s[c];
                            mRun[k][c] = 0;
                        end
                    end
                end
                mRise[k] = nd & ~mDout[k];
                mFall[k] = ~nd & mDout[k];
                mDout[k] = nd;
            end
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = din;
        end
    end

    task automatic checkOutput(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkIndex(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Every cycle, both instances are held against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("A.dout", busA.dout, mDout[0]);
            checkOutput("A.rise", busA.rise, mRise[0]);
            checkOutput("A.fall", busA.fall, mFall[0]);
            checkOutput("B.dout", busB.dout, mDout[1]);
            checkOutput("B.rise", busB.rise, mRise[1]);
            checkOutput("B.fall", busB.fall, mFall[1]);
        end
    end

    task automatic nextSample();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] d, input logic [NCH-1:0] m, input logic t);
        din  = d;
        mode = m;
        tick = t;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2 rst_p = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_p = 1'b0;
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin : stim
        int fallCount;
        int riseCount;
        int fallIdx;
        int riseIdx;
        bit tickAlways;
        logic pat [10];

        #1 rst_p = 1'b1;
        applyStimulus(4'hF, 4'h0, 1'b1);
        checkEn = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset dout", busA.dout, 4'h0);
        checkOutput("reset rise", busA.rise, 4'h0);
        checkOutput("reset fall", busA.fall, 4'h0);

        @(posedge clk);
        #2 rst_p = 1'b0;
        repeat (2) nextSample();
        checkOutput("post-reset dout E2", busA.dout, 4'h0);
        nextSample();
        checkOutput("post-reset dout E3", busA.dout, 4'hF);
        checkOutput("post-reset rise E3", busA.rise, 4'hF);
        checkOutput("model dout E3", mDout[0], 4'hF);
        checkOutput("hold1 dout E3", busB.dout, 4'hF);
        nextSample();
        checkOutput("post-reset rise E4", busA.rise, 4'h0);

        // Fast-attack release: hold-5 falls on the fifth zero sample,
        // hold-1 on the first.
        din = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            nextSample();
            if (k == 3) begin
                checkOutput("hold1 release dout", busB.dout, 4'h0);
                checkOutput("hold1 release fall", busB.fall, 4'hF);
            end
            if (k == 6) checkOutput("fast dout held", busA.dout, 4'hF);
            if (k == 7) begin
                checkOutput("fast release dout", busA.dout, 4'h0);
                checkOutput("fast release fall", busA.fall, 4'hF);
            end
            if (k == 8) checkOutput("fast fall one cycle", busA.fall, 4'h0);
        end

        // Bounce rejection in fast mode.
        din = 4'hF;
        repeat (6) nextSample();
        pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        fallCount = 0;
        riseCount = 0;
        fallIdx   = -1;
        for (int k = 0; k < 14; k++) begin
            din = (k < 10) ? {NCH{pat[k]}} : 4'h0;
            nextSample();
            if (busA.fall != 4'h0) begin
                fallCount++;
                fallIdx = k;
            end
            if (busA.rise != 4'h0) riseCount++;
        end
        checkIndex("bounce fall count", fallCount, 1);
        checkIndex("bounce fall index", fallIdx, 11);
        checkIndex("bounce rise count", riseCount, 0);

        // Symmetric mode: four high samples are not enough, five are.
        mode = 4'hF;
        riseCount = 0;
        for (int k = 0; k < 12; k++) begin
            din = (k < 4) ? 4'hF : 4'h0;
            nextSample();
            if (busA.rise != 4'h0) riseCount++;
        end
        checkIndex("sym short rise count", riseCount, 0);
        riseIdx = -1;
        for (int k = 0; k < 12; k++) begin
            din = 4'hF;
            nextSample();
            if (busA.rise != 4'h0 && riseIdx < 0) riseIdx = k;
        end
        checkIndex("sym rise index", riseIdx, 6);

        // Tick gating, one tick in four, without and with a non-tick glitch.
        applyStimulus(4'h0, 4'hF, 1'b1);
        repeat (10) nextSample();
        riseIdx = -1;
        for (int k = 0; k < 40; k++) begin
            din  = 4'hF;
            tick = (k % 4 == 0);
            nextSample();
            if (busA.rise != 4'h0 && riseIdx < 0) riseIdx = k;
        end
        checkIndex("tick rise index", riseIdx, 20);
        applyStimulus(4'h0, 4'hF, 1'b1);
        repeat (10) nextSample();
        riseIdx = -1;
        for (int k = 0; k < 40; k++) begin
            din  = (k == 8) ? 4'h0 : 4'hF;
            tick = (k % 4 == 0);
            nextSample();
            if (busA.rise != 4'h0 && riseIdx < 0) riseIdx = k;
        end
        checkIndex("glitch rise index", riseIdx, 28);

        // Mode switch 1->0 on ch2 while its input is high and dout is low.
        applyStimulus(4'h0, 4'hF, 1'b1);
        repeat (10) nextSample();
        din = 4'h4;
        repeat (3) nextSample();
        checkOutput("pre-switch dout", busA.dout, 4'h0);
        mode = 4'hB;
        nextSample();
        checkOutput("switch dout", busA.dout, 4'h4);
        checkOutput("switch rise", busA.rise, 4'h4);

        // Randomized soak with runs on each channel, mode flips, tick
        // gating and occasional mid-count reset.
        tickAlways = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(5) == 0) din[c] = ~din[c];
                if ($urandom_range(59) == 0) mode[c] = ~mode[c];
            end
            if (n % 200 == 0) tickAlways = ($urandom_range(1) == 1);
            tick = tickAlways ? 1'b1 : ($urandom_range(2) == 0);
            if ($urandom_range(399) == 0) pulseReset();
        end

        @(negedge clk);
        checkEn = 1'b0;
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
